hp54542c_lcd_tx: RTL and testbench

//  Transmit side of the HP54542C LCD pixel interface: emits a one-pulse-per-frame

---
 rtl/hp54542c_lcd_tx.sv | 159 +++++++++++++++
 tb/tb_hp54542c_lcd_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hp54542c_lcd_tx.sv
// rtl/hp54542c_lcd_tx.sv - HP54542C LCD pixel transmitter (frame RAM or test-pattern source)
module hp54542c_lcd_tx #(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int SYNC_WIDTH = 1,
    parameter int ADDR_W     = 19
) (
    input  logic              iw_clk,
    input  logic              reset,
    input  logic              iw_enable,
    input  logic [1:0]        iw_pattern,
    output logic              ow_pix_req,
    output logic [ADDR_W-1:0] ow_pix_addr,
    input  logic [2:0]        iw_pix_rgb,
    output logic              ow_sync,
    output logic              ow_r0,
    output logic              ow_g0,
    output logic              ow_b0,
    output logic              ow_frame_done,
    output logic              ow_busy
);

    // Counters are at least 4 bits so the checkerboard can always use bit 3.
    localparam int HW    = ($clog2(H_TOTAL + 1) > 4) ? $clog2(H_TOTAL + 1) : 4;
    localparam int VW    = ($clog2(V_TOTAL + 1) > 4) ? $clog2(V_TOTAL + 1) : 4;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state;
    state_t            state_next;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        pat_q;
    logic [HW-1:0]     bar_sub;
    logic [2:0]        bar_idx;

    logic              scan;
    logic              h_last;
    logic              v_last;
    logic              frame_end;
    logic              active;
    logic              start;
    logic              sync0;
    logic [2:0]        pat_rgb;

    logic              s1_busy;
    logic              s1_sync;
    logic              s1_done;
    logic              s1_ram;
    logic [2:0]        s1_rgb;

    assign scan      = (state == SCAN);
    assign h_last    = (hcnt == HW'(H_TOTAL - 1));
    assign v_last    = (vcnt == VW'(V_TOTAL - 1));
    assign frame_end = scan && h_last && v_last;
    assign active    = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    assign start     = iw_enable && ((state == IDLE) || frame_end);

    always_ff @(posedge iw_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iw_enable) state_next = SCAN;
            SCAN:    if (frame_end && !iw_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ow_pix_req  = scan && active && (pat_q == 2'd0);
        ow_pix_addr = addr;
        sync0       = scan && (vcnt == '0) && (hcnt < HW'(SYNC_WIDTH));
        pat_rgb     = 3'b000;
        if (active) begin
            case (pat_q)
                2'd1:    pat_rgb = 3'b111;
                2'd2:    pat_rgb = bar_idx;
                2'd3:    pat_rgb = (hcnt[3] ^ vcnt[3]) ? 3'b111 : 3'b000;
                default: pat_rgb = 3'b000;
            endcase
        end
    end

    // Counters only move in SCAN; every exit to IDLE happens on the wrap, so IDLE sees zeros.
    always_ff @(posedge iw_clk) begin
        if (reset) begin
            hcnt    <= '0;
            vcnt    <= '0;
            addr    <= '0;
            pat_q   <= 2'd0;
            bar_sub <= '0;
            bar_idx <= 3'd0;
        end else begin
            if (start) begin
                pat_q <= iw_pattern;
            end
            if (scan) begin
                if (h_last) begin
                    hcnt    <= '0;
                    vcnt    <= v_last ? '0 : vcnt + 1'b1;
                    bar_sub <= '0;
                    bar_idx <= 3'd0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                    if (bar_sub == HW'(BAR_W - 1)) begin
                        bar_sub <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else begin
                        bar_sub <= bar_sub + 1'b1;
                    end
                end
                if (frame_end) begin
                    addr <= '0;
                end else if (active) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

    // Stage 1 waits for the RAM read; stage 2 picks RAM data or the pattern colour.
    always_ff @(posedge iw_clk) begin
        if (reset) begin
            s1_busy       <= 1'b0;
            s1_sync       <= 1'b0;
            s1_done       <= 1'b0;
            s1_ram        <= 1'b0;
            s1_rgb        <= 3'b000;
            ow_sync       <= 1'b0;
            ow_r0         <= 1'b0;
            ow_g0         <= 1'b0;
            ow_b0         <= 1'b0;
            ow_frame_done <= 1'b0;
            ow_busy       <= 1'b0;
        end else begin
            s1_busy       <= scan;
            s1_sync       <= sync0;
            s1_done       <= frame_end;
            s1_ram        <= ow_pix_req;
            s1_rgb        <= pat_rgb;
            ow_sync       <= s1_sync;
            ow_frame_done <= s1_done;
            ow_busy       <= s1_busy;
            {ow_r0, ow_g0, ow_b0} <= s1_ram ? iw_pix_rgb : s1_rgb;
        end
    end

endmodule

// File: tb/tb_hp54542c_lcd_tx.sv
// tb/tb_hp54542c_lcd_tx.sv - directed self-checking bench for hp54542c_lcd_tx (reduced geometry)
module tb_hp54542c_lcd_tx;

    localparam int HA = 16, HT = 20, VA = 16, VT = 18, SW = 2, AW = 9;
    localparam int FR = HT * VT;

    logic          clk = 1'b0;
    logic          reset;
    logic          iw_enable;
    logic [1:0]    iw_pattern;
    logic          ow_pix_req;
    logic [AW-1:0] ow_pix_addr;
    logic [2:0]    iw_pix_rgb;
    logic          ow_sync, ow_r0, ow_g0, ow_b0, ow_frame_done, ow_busy;

    int total = 0;
    int bad   = 0;

    logic [2:0]    rgb_a  [FR];
    logic          sync_a [FR];
    logic          busy_a [FR];
    logic          done_a [FR];
    logic          req_a  [FR];
    logic [AW-1:0] addr_a [FR];

    hp54542c_lcd_tx #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SYNC_WIDTH(SW), .ADDR_W(AW)
    ) dut (
        .iw_clk(clk), .reset(reset), .iw_enable(iw_enable), .iw_pattern(iw_pattern),
        .ow_pix_req(ow_pix_req), .ow_pix_addr(ow_pix_addr), .iw_pix_rgb(iw_pix_rgb),
        .ow_sync(ow_sync), .ow_r0(ow_r0), .ow_g0(ow_g0), .ow_b0(ow_b0),
        .ow_frame_done(ow_frame_done), .ow_busy(ow_busy)
    );

    always #5 clk = ~clk;

    // Frame RAM model: data = addr[2:0], one clock after the request.
    always @(posedge clk) iw_pix_rgb <= ow_pix_req ? ow_pix_addr[2:0] : 3'b101;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx(input int h, input int v);
        return v * HT + h;
    endfunction

    function automatic logic [2:0] exp_rgb(input logic [1:0] p, input int h, input int v);
        if (!(h < HA && v < VA)) return 3'b000;
        case (p)
            2'd0:    return 3'((v * HA + h) % 8);
            2'd1:    return 3'b111;
            2'd2:    return 3'(h / (HA / 8));
            default: return (((h / 8) % 2) != ((v / 8) % 2)) ? 3'b111 : 3'b000;
        endcase
    endfunction

    task automatic wait_sync(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!ow_sync && n < 2000);
    endtask

    task automatic capture(input int chg_k, input logic [1:0] np, input logic ne);
        for (int k = 0; k < FR; k++) begin
            if (k > 0) @(negedge clk);
            rgb_a[k]  = {ow_r0, ow_g0, ow_b0};
            sync_a[k] = ow_sync;
            busy_a[k] = ow_busy;
            done_a[k] = ow_frame_done;
            req_a[k]  = ow_pix_req;
            addr_a[k] = ow_pix_addr;
            if (k == chg_k) begin
                iw_pattern = np;
                iw_enable  = ne;
            end
        end
    endtask

    task automatic verify(input logic [1:0] p, input string tag);
        int errs;
        errs = 0;
        for (int k = 0; k < FR; k++) begin
            int h, v;
            h = k % HT;
            v = k / HT;
            if (rgb_a[k] !== exp_rgb(p, h, v)) errs++;
            if (sync_a[k] !== (v == 0 && h < SW)) errs++;
            if (busy_a[k] !== 1'b1) errs++;
            if (done_a[k] !== (k == FR - 1)) errs++;
        end
        check(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, errs;
        reset      = 1'b1;
        iw_enable  = 1'b0;
        iw_pattern = 2'd0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outs", {ow_sync, ow_r0, ow_g0, ow_b0, ow_frame_done, ow_busy, ow_pix_req}, 7'd0);
        check("reset_addr", 32'(ow_pix_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_outs", {ow_sync, ow_busy, ow_pix_req}, 3'd0);

        // Frame A: solid white; pattern switched to bars mid-frame.
        iw_enable  = 1'b1;
        iw_pattern = 2'd1;
        wait_sync(n);
        check("first_sync_lat", 32'(n), 32'd3);
        capture(5, 2'd2, 1'b1);
        verify(2'd1, "frame_white");
        check("white_h15", 32'(rgb_a[idx(15, 0)]), 32'h7);
        check("white_h16", 32'(rgb_a[idx(16, 0)]), 32'h0);
        check("white_v16", 32'(rgb_a[idx(0, 16)]), 32'h0);
        @(negedge clk);
        check("period_a", 32'(ow_sync), 32'd1);

        // Frame B: colour bars; checkerboard requested mid-frame.
        capture(40, 2'd3, 1'b1);
        verify(2'd2, "frame_bars");
        check("bar_h0", 32'(rgb_a[idx(0, 0)]), 32'h0);
        check("bar_h1", 32'(rgb_a[idx(1, 0)]), 32'h0);
        check("bar_h2", 32'(rgb_a[idx(2, 0)]), 32'h1);
        check("bar_h15", 32'(rgb_a[idx(15, 0)]), 32'h7);
        check("bar_h16", 32'(rgb_a[idx(16, 0)]), 32'h0);
        @(negedge clk);
        check("period_b", 32'(ow_sync), 32'd1);

        // Frame C: checkerboard; RAM source requested mid-frame.
        capture(100, 2'd0, 1'b1);
        verify(2'd3, "frame_checker");
        check("chk_h8_v0", 32'(rgb_a[idx(8, 0)]), 32'h7);
        check("chk_h8_v8", 32'(rgb_a[idx(8, 8)]), 32'h0);
        check("chk_h0_v8", 32'(rgb_a[idx(0, 8)]), 32'h7);
        @(negedge clk);
        check("period_c", 32'(ow_sync), 32'd1);

        // Frame D: RAM source; enable dropped mid-frame, frame must still complete.
        capture(10, 2'd0, 1'b0);
        verify(2'd0, "frame_ram");
        check("ram_h3_v0", 32'(rgb_a[idx(3, 0)]), 32'h3);
        check("ram_h7_v1", 32'(rgb_a[idx(7, 1)]), 32'h7);
        check("ram_h5_v2", 32'(rgb_a[idx(5, 2)]), 32'h5);
        errs = 0;
        for (int k = 0; k < FR; k++) begin
            int p, h, v;
            logic act;
            p = k + 2;
            h = p % HT;
            v = p / HT;
            act = (p < FR) && (h < HA) && (v < VA);
            if (req_a[k] !== act) errs++;
            if (act && addr_a[k] !== AW'(v * HA + h)) errs++;
        end
        check("req_addr_seq", 32'(errs), 32'd0);
        check("addr_line1_h0", 32'(addr_a[idx(0, 1) - 2]), 32'd16);
        check("addr_last", 32'(addr_a[idx(15, 15) - 2]), 32'd255);
        check("req_blank", 32'(req_a[idx(16, 0) - 2]), 32'd0);

        errs = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ({ow_sync, ow_r0, ow_g0, ow_b0, ow_frame_done, ow_busy, ow_pix_req} != 7'd0) errs++;
            if (ow_pix_addr != '0) errs++;
        end
        check("drain_quiet", 32'(errs), 32'd0);

        // Reset mid-frame, then restart from (0,0) with the RAM source.
        iw_enable  = 1'b1;
        iw_pattern = 2'd1;
        wait_sync(n);
        check("restart_sync_lat", 32'(n), 32'd3);
        repeat (10 * HT) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outs", {ow_sync, ow_r0, ow_g0, ow_b0, ow_frame_done, ow_busy, ow_pix_req}, 7'd0);
        check("midreset_addr", 32'(ow_pix_addr), 32'd0);
        reset      = 1'b0;
        iw_pattern = 2'd0;
        @(posedge clk);
        @(negedge clk);
        check("restart_req", {ow_pix_req, ow_sync}, 2'b10);
        check("restart_addr", 32'(ow_pix_addr), 32'd0);
        wait_sync(n);
        check("restart_sync", 32'(n), 32'd2);
        check("restart_rgb0", 32'({ow_r0, ow_g0, ow_b0}), 32'h0);
        @(negedge clk);
        check("restart_rgb1", 32'({ow_r0, ow_g0, ow_b0}), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
